// File: rtl/alu_md_if.sv
// alu_md_if -- request/response bundle for the alu_md execution unit.
//
// Request side : in_valid/in_ready handshake carrying src_a, src_b, alu_control.
// Response side: out_valid/out_ready handshake carrying alu_result and zero.
// busy flags an iterative multiply/divide in flight.
//
// master : the requester and consumer (drives requests, takes results).
// slave  : the execution unit itself.
interface alu_md_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [4:0]      alu_control;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_result;
  logic            zero;
  logic            busy;

  modport master (
    output in_valid, src_a, src_b, alu_control, out_ready,
    input  in_ready, out_valid, alu_result, zero, busy
  );

  modport slave (
    input  in_valid, src_a, src_b, alu_control, out_ready,
    output in_ready, out_valid, alu_result, zero, busy
  );
endinterface

// File: rtl/alu_md.sv
// alu_md -- integer ALU with iterative RISC-V M-extension multiply/divide.
//
// Ports:
//   clk   : sole clock, rising edge.
//   reset : asynchronous active-high reset.
//   bus   : alu_md_if.slave -- request (in_valid/in_ready, src_a, src_b,
//           alu_control), response (out_valid/out_ready, alu_result, zero),
//           and busy status.
//
// Opcodes 0-9 and 18-31 complete in one cycle (result registered at accept).
// Opcodes 10-17 run XLEN radix-2 steps on operand magnitudes; the sign fix-up
// is folded into the last step so the result lands in the same cycle.
module alu_md #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input logic     clk,
  input logic     reset,
  alu_md_if.slave bus
);
  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_SLT = 5'd2,  OP_SLTU = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4,  OP_OR  = 5'd5,  OP_AND = 5'd6,  OP_SLL  = 5'd7;
  localparam logic [4:0] OP_SRL = 5'd8,  OP_SRA = 5'd9,  OP_MUL = 5'd10, OP_MULH = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV = 5'd14;
  localparam logic [4:0] OP_DIVU = 5'd15, OP_REM = 5'd16, OP_REMU = 5'd17;
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(XLEN-1);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state_reg, state_next;
  logic [4:0]      op_reg, op_next;
  logic [XLEN-1:0] hi_reg, hi_next;       // mul: partial product upper half; div: remainder
  logic [XLEN-1:0] lo_reg, lo_next;       // mul: multiplier/product low half; div: dividend/quotient
  logic [XLEN-1:0] b_reg, b_next;         // multiplicand or divisor magnitude
  logic            neg_reg, neg_next;     // negate the selected result at the end
  logic [SHW:0]    count_reg, count_next;
  logic [XLEN-1:0] result_reg, result_next;

  logic            accept;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] single_res;
  logic            is_md, a_signed, b_signed, a_neg, b_neg, neg_in;
  logic [XLEN-1:0] a_mag, b_mag;

  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   mul_hi, mul_lo;
  logic [XLEN:0]     div_shift, div_diff;
  logic [XLEN-1:0]   div_hi, div_lo;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, md_res;

  assign bus.in_ready   = (state_reg == S_IDLE) || (state_reg == S_DONE && bus.out_ready);
  assign bus.out_valid  = (state_reg == S_DONE);
  assign bus.busy       = (state_reg == S_BUSY);
  assign bus.alu_result = result_reg;
  assign bus.zero       = (result_reg == '0);
  assign accept         = bus.in_valid && bus.in_ready;

  // Single-cycle datapath, evaluated on the live request operands.
  assign shamt = bus.src_b[SHW-1:0];
  always_comb begin
    single_res = '0;
    case (bus.alu_control)
      OP_ADD:  single_res = bus.src_a + bus.src_b;
      OP_SUB:  single_res = bus.src_a - bus.src_b;
      OP_SLT:  single_res = {{(XLEN-1){1'b0}}, $signed(bus.src_a) < $signed(bus.src_b)};
      OP_SLTU: single_res = {{(XLEN-1){1'b0}}, bus.src_a < bus.src_b};
      OP_XOR:  single_res = bus.src_a ^ bus.src_b;
      OP_OR:   single_res = bus.src_a | bus.src_b;
      OP_AND:  single_res = bus.src_a & bus.src_b;
      OP_SLL:  single_res = bus.src_a << shamt;
      OP_SRL:  single_res = bus.src_a >> shamt;
      OP_SRA:  single_res = $signed(bus.src_a) >>> shamt;
      default: single_res = '0;
    endcase
  end

  // Operand preparation for the iterative unit.
  assign is_md    = (bus.alu_control >= OP_MUL) && (bus.alu_control <= OP_REMU);
  assign a_signed = (bus.alu_control == OP_MUL) || (bus.alu_control == OP_MULH) ||
                    (bus.alu_control == OP_MULHSU) || (bus.alu_control == OP_DIV) ||
                    (bus.alu_control == OP_REM);
  assign b_signed = (bus.alu_control == OP_MUL) || (bus.alu_control == OP_MULH) ||
                    (bus.alu_control == OP_DIV) || (bus.alu_control == OP_REM);
  assign a_neg    = a_signed && bus.src_a[XLEN-1];
  assign b_neg    = b_signed && bus.src_b[XLEN-1];
  assign a_mag    = a_neg ? -bus.src_a : bus.src_a;
  assign b_mag    = b_neg ? -bus.src_b : bus.src_b;

  // Divide-by-zero: the unsigned iteration already yields an all-ones
  // quotient and remainder = |src_a|, so the quotient must not be negated;
  // the remainder keeps the dividend's sign, which restores src_a exactly.
  always_comb begin
    neg_in = 1'b0;
    case (bus.alu_control)
      OP_MUL, OP_MULH, OP_MULHSU: neg_in = a_neg ^ b_neg;
      OP_DIV:                     neg_in = (a_neg ^ b_neg) && (bus.src_b != '0);
      OP_REM:                     neg_in = a_neg;
      default:                    neg_in = 1'b0;
    endcase
  end

  // One shift-add multiply step: conditionally add, then shift {hi,lo} right.
  assign mul_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
  assign mul_hi  = mul_sum[XLEN:1];
  assign mul_lo  = {mul_sum[0], lo_reg[XLEN-1:1]};

  // One restoring divide step: shift next dividend bit into the remainder, try subtract.
  assign div_shift = {hi_reg, lo_reg[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, b_reg};
  assign div_hi    = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
  assign div_lo    = {lo_reg[XLEN-2:0], ~div_diff[XLEN]};

  // Final-step result selection including sign correction.
  assign prod     = {mul_hi, mul_lo};
  assign prod_fix = neg_reg ? -prod : prod;
  assign quot_fix = neg_reg ? -div_lo : div_lo;
  assign rem_fix  = neg_reg ? -div_hi : div_hi;
  always_comb begin
    md_res = rem_fix;
    case (op_reg)
      OP_MUL:                       md_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: md_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              md_res = quot_fix;
      default:                      md_res = rem_fix;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    b_next      = b_reg;
    neg_next    = neg_reg;
    count_next  = count_reg;
    result_next = result_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (state_reg == S_DONE && bus.out_ready) state_next = S_IDLE;
        if (accept) begin
          op_next    = bus.alu_control;
          count_next = '0;
          if (is_md) begin
            hi_next    = '0;
            lo_next    = a_mag;
            b_next     = b_mag;
            neg_next   = neg_in;
            state_next = S_BUSY;
          end else begin
            result_next = single_res;
            state_next  = S_DONE;
          end
        end
      end
      S_BUSY: begin
        count_next = count_reg + CNT_ONE;
        if (op_reg >= OP_DIV) begin
          hi_next = div_hi;
          lo_next = div_lo;
        end else begin
          hi_next = mul_hi;
          lo_next = mul_lo;
        end
        if (count_reg == CNT_LAST) begin
          count_next  = count_reg;   // hold at the last value rather than wrap
          result_next = md_res;
          state_next  = S_DONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      op_reg     <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      b_reg      <= '0;
      neg_reg    <= 1'b0;
      count_reg  <= '0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      b_reg      <= b_next;
      neg_reg    <= neg_next;
      count_reg  <= count_next;
      result_reg <= result_next;
    end
  end
endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md -- directed scoreboard bench for alu_md (XLEN=32).
// Stimulus pushes hand-computed expected results into a queue; a monitor
// pops and compares whenever a result is handed over (out_valid && out_ready).
module tb_alu_md;
  localparam int XLEN = 32;
  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_SLT = 5'd2,  OP_SLTU = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4,  OP_OR  = 5'd5,  OP_AND = 5'd6,  OP_SLL  = 5'd7;
  localparam logic [4:0] OP_SRL = 5'd8,  OP_SRA = 5'd9,  OP_MUL = 5'd10, OP_MULH = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV = 5'd14;
  localparam logic [4:0] OP_DIVU = 5'd15, OP_REM = 5'd16, OP_REMU = 5'd17;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_md_if #(.XLEN(XLEN)) bus();
  alu_md #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [31:0] exp_q[$];
  string       name_q[$];
  int checks = 0, passes = 0, out_seen = 0, stalls = 0;
  logic [31:0] mon_exp;
  string       mon_name;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      out_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_result: got 0x%08h expected no result", bus.alu_result);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        $display("txn %s: result=0x%08h expected=0x%08h zero=%0b", mon_name, bus.alu_result, mon_exp, bus.zero);
        chk({mon_name, "_result"}, bus.alu_result, mon_exp);
        chk({mon_name, "_zero"}, bus.zero, mon_exp == 32'd0);
      end
    end
  end

  // Present a request and hold it until accepted; leaves in_valid high.
  task automatic issue(input string nm, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] e, input bit expect_out);
    int n;
    bus.in_valid = 1'b1;
    bus.alu_control = op;
    bus.src_a = a;
    bus.src_b = b;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      $display("FAIL accept_timeout_%s: got in_ready=0 expected 1", nm);
    end
    stalls += n;
    if (expect_out) begin
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    bus.in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, lat, bad;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.alu_control = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_result", bus.alu_result, 0);
    chk("rst_zero", bus.zero, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // First accept on the first edge after release; result one cycle later.
    issue("add_5_7", OP_ADD, 32'd5, 32'd7, 32'd12, 1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("add_latency_valid", bus.out_valid, 1);
    @(posedge clk);
    #1;

    // Back-to-back single-cycle ops: no stalls, one result per cycle.
    base = out_seen;
    stalls = 0;
    issue("sub_3_3",   OP_SUB,  32'd3,         32'd3,         32'd0,         1);
    issue("sra",       OP_SRA,  32'h8000_0000, 32'd4,         32'hF800_0000, 1);
    issue("srl",       OP_SRL,  32'h8000_0000, 32'd4,         32'h0800_0000, 1);
    issue("slt",       OP_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1,         1);
    issue("sltu",      OP_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0,         1);
    issue("xor",       OP_XOR,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1);
    issue("or",        OP_OR,   32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1);
    issue("and",       OP_AND,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1);
    issue("sll_31",    OP_SLL,  32'd1,         32'd31,        32'h8000_0000, 1);
    issue("op25_zero", 5'd25,   32'd5,         32'd7,         32'd0,         1);
    issue("add_wrap",  OP_ADD,  32'hFFFF_FFFF, 32'd1,         32'd0,         1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("b2b_stalls", stalls, 0);
    chk("b2b_results", out_seen - base, 11);
    @(posedge clk);
    #1;

    // MULHU latency and busy window.
    issue("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1);
    bus.in_valid = 1'b0;
    lat = 0;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
      if (!bus.busy || bus.in_ready) bad++;
    end
    chk("mulhu_latency", lat, 33);
    chk("mulhu_busy_window", bad, 0);
    @(posedge clk);
    #1;

    issue("mul_ff",     OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         1);
    issue("mulh_ff",    OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         1);
    issue("mulhsu",     OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1);
    issue("mul_7_m3",   OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1);
    issue("div_ovf",    OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    issue("rem_ovf",    OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
    issue("divu_7_0",   OP_DIVU,   32'd7,         32'd0,         32'hFFFF_FFFF, 1);
    issue("remu_7_0",   OP_REMU,   32'd7,         32'd0,         32'd7,         1);
    issue("div_m7_2",   OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1);
    issue("rem_m7_2",   OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1);
    issue("div_7_m2",   OP_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1);
    issue("rem_7_m2",   OP_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         1);
    issue("div_m7_0",   OP_DIV,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1);
    issue("rem_m7_0",   OP_REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1);
    issue("divu_100_7", OP_DIVU,   32'd100,       32'd7,         32'd14,        1);
    issue("remu_100_7", OP_REMU,   32'd100,       32'd7,         32'd2,         1);
    drain();

    // Backpressure: result must hold and no new accept while out_ready is low.
    bus.out_ready = 1'b0;
    issue("bp_add_1_2", OP_ADD, 32'd1, 32'd2, 32'd3, 1);
    bus.src_a = 32'd10;
    bus.src_b = 32'd20;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!bus.out_valid || bus.alu_result != 32'd3 || bus.in_ready || bus.zero) bad++;
    end
    chk("bp_hold", bad, 0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    exp_q.push_back(32'd30);
    name_q.push_back("bp_add_10_20");
    @(negedge clk);
    chk("bp_release_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    drain();

    // Reset in the middle of a divide discards it.
    issue("divu_abort", OP_DIVU, 32'd1000, 32'd3, 32'd0, 0);
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_busy_before", bus.busy, 1);
    reset = 1'b1;
    #1;
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_in_ready", bus.in_ready, 1);
    chk("abort_result", bus.alu_result, 0);
    base = out_seen;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (50) @(negedge clk);
    chk("abort_no_stale", out_seen - base, 0);
    chk("abort_idle_out_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;

    issue("add_after_rst", OP_ADD, 32'd2, 32'd2, 32'd4, 1);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
